// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit_pkg
//  Description : Shared state encoding and constants for the hazard / stall
//                controller of the 5-stage RISC-V core.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_stall_unit_pkg;

    // Register index width used by the ID and EX stage operand fields
    localparam int c_REG_AW      = 5;
    // Stages behind ID (EX, MEM, WB) that must empty before a fence issues
    localparam int c_DRAIN_DEPTH = 3;

    // Controller states; the encoding is visible on hz_state for debug
    typedef enum logic [1:0] {
        HZ_RUN     = 2'b00,
        HZ_DRAIN   = 2'b01,
        HZ_HALT    = 2'b10,
        HZ_ILLEGAL = 2'b11
    } hz_state_t;

endpackage : hazard_stall_unit_pkg
`default_nettype wire

// File: rtl/hazard_stall_unit_occupancy.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_occupancy_tracker
//  Description : Shift register that follows every instruction issued out of
//                ID down the back end of the pipe. Empty means no instruction
//                is still in flight behind ID.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_occupancy_tracker #(
    parameter int DRAIN_DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic empty
);

    logic [DRAIN_DEPTH-1:0] r_occ;

    generate
        if (DRAIN_DEPTH == 1) begin : g_single
            // A single tracked stage simply records last cycle's issue
            always_ff @(posedge clk) begin
                if (!rst_n) r_occ <= '0;
                else        r_occ <= issue;
            end
        end else begin : g_shift
            // Each issued instruction walks one bit per cycle toward retire
            always_ff @(posedge clk) begin
                if (!rst_n) r_occ <= '0;
                else        r_occ <= {r_occ[DRAIN_DEPTH-2:0], issue};
            end
        end
    endgenerate

    assign empty = (r_occ == '0);

endmodule : pipe_occupancy_tracker
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Pipeline hold / flush controller beside the ID stage.
//                Resolves, highest priority first: taken-branch flush,
//                break halt with external resume, fence drain, and the
//                single-cycle load-use bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int DRAIN_DEPTH = c_DRAIN_DEPTH,
    parameter int REG_AW      = c_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [1:0]        id_rs_use,
    input  logic              id_fence,
    input  logic              id_break,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              resume,
    output logic              stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [1:0]        hz_state
);

    hz_state_t r_state;
    hz_state_t w_next_state;
    logic      w_lu;
    logic      w_issue;
    logic      w_empty;

    // An instruction leaves ID only when it is real and neither held nor killed
    assign w_issue = id_valid & ~stall & ~idex_flush;

    pipe_occupancy_tracker #(
        .DRAIN_DEPTH (DRAIN_DEPTH)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (w_issue),
        .empty (w_empty)
    );

    // Load in EX writing a register that the ID instruction actually reads
    always_comb begin
        w_lu = id_valid & ex_memread & (ex_rd != '0) &
               (((ex_rd == id_rs1) & id_rs_use[0]) |
                ((ex_rd == id_rs2) & id_rs_use[1]));
    end

    // State register; reset aborts any DRAIN or HALT in progress
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= HZ_RUN;
        else        r_state <= w_next_state;
    end

    // Priority resolution of hold, flush and next state
    always_comb begin
        stall        = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        halted       = 1'b0;
        w_next_state = r_state;

        if (!rst_n) begin
            // Freeze fetch for the reset cycle; nothing issues
            stall        = 1'b1;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            w_next_state = HZ_RUN;
        end else if (ex_branch_taken && (r_state != HZ_HALT)) begin
            // Redirect kills whatever sits in IF/ID and ID, fences included
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            w_next_state = HZ_RUN;
        end else begin
            case (r_state)
                HZ_RUN: begin
                    if (id_valid && id_break) begin
                        stall        = 1'b1;
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        w_next_state = HZ_HALT;
                    end else if (id_valid && id_fence && !w_empty) begin
                        stall        = 1'b1;
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        w_next_state = HZ_DRAIN;
                    end else if (w_lu) begin
                        stall   = 1'b1;
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end
                end
                HZ_DRAIN: begin
                    if (!w_empty) begin
                        stall   = 1'b1;
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end else begin
                        // Back end is empty: let the fence issue this cycle
                        w_next_state = HZ_RUN;
                    end
                end
                HZ_HALT: begin
                    halted = 1'b1;
                    stall  = 1'b1;
                    if (resume) begin
                        // Break retires as a bubble while fetch moves on
                        pc_en        = 1'b1;
                        ifid_flush   = 1'b1;
                        w_next_state = HZ_RUN;
                    end else begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: hold one cycle and recover
                    stall        = 1'b1;
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    w_next_state = HZ_RUN;
                end
            endcase
        end
    end

    assign hz_state = r_state;

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Directed self-checking bench for hazard_stall_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [1:0] id_rs_use;
    logic       id_fence;
    logic       id_break;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       ex_branch_taken;
    logic       resume;
    logic       stall;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       halted;
    logic [1:0] hz_state;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(
        .DRAIN_DEPTH (3),
        .REG_AW      (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs_use       (id_rs_use),
        .id_fence        (id_fence),
        .id_break        (id_break),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .resume          (resume),
        .stall           (stall),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halted          (halted),
        .hz_state        (hz_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs_use = 2'b00;
        id_fence = 0; id_break = 0; ex_rd = 0; ex_memread = 0;
        ex_branch_taken = 0; resume = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        // Reset cycle
        settle();
        check("rst_stall",  stall,  1);
        check("rst_pc_en",  pc_en,  0);
        check("rst_ifid_en", ifid_en, 0);
        check("rst_halted", halted, 0);
        tick();
        rst_n = 1;
        settle();
        check("post_rst_state", hz_state, 0);
        check("post_rst_stall", stall, 0);
        check("post_rst_pc_en", pc_en, 1);
        tick();

        // Load-use on rs1
        id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_rs_use = 2'b01;
        settle();
        check("lu_stall",   stall,   1);
        check("lu_pc_en",   pc_en,   0);
        check("lu_ifid_en", ifid_en, 0);
        tick();
        ex_memread = 0; ex_rd = 0;
        settle();
        check("lu_after_stall", stall, 0);
        check("lu_after_pc_en", pc_en, 1);
        tick();
        // Load to x0 never stalls
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs_use = 2'b01;
        settle();
        check("lu_x0_stall", stall, 0);
        tick();
        // Match on rs2 only counts when rs2 is read
        ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_rs_use = 2'b10;
        settle();
        check("lu_rs2_stall", stall, 1);
        tick();
        id_rs_use = 2'b01;
        settle();
        check("lu_rs2_unused_stall", stall, 0);
        tick();

        // Empty the back end
        idle();
        tick(); tick(); tick();
        settle();
        check("drained_occ", dut.u_occ.r_occ, 0);

        // Three issues then a fence
        id_valid = 1;
        tick(); tick(); tick();
        id_fence = 1;
        settle();
        check("fence_a_stall", stall, 1);
        check("fence_a_pc_en", pc_en, 0);
        tick();
        settle();
        check("fence_b_state", hz_state, 1);
        check("fence_b_stall", stall, 1);
        tick();
        settle();
        check("fence_c_stall", stall, 1);
        tick();
        settle();
        check("fence_d_stall", stall, 0);
        check("fence_d_pc_en", pc_en, 1);
        tick();
        id_fence = 0; id_valid = 0;
        settle();
        check("fence_done_state", hz_state, 0);
        tick(); tick(); tick();

        // Fence with nothing in flight issues at once
        id_valid = 1; id_fence = 1;
        settle();
        check("fence_empty_stall", stall, 0);
        tick();
        idle();
        settle();
        check("fence_empty_state", hz_state, 0);
        tick();

        // Break, idle in HALT, resume
        id_valid = 1; id_break = 1;
        settle();
        check("brk_stall",  stall,  1);
        check("brk_pc_en",  pc_en,  0);
        check("brk_halted", halted, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            settle();
            check("halt_halted", halted, 1);
            check("halt_pc_en",  pc_en,  0);
            tick();
        end
        resume = 1;
        settle();
        check("resume_ifid_flush", ifid_flush, 1);
        check("resume_pc_en",      pc_en,      1);
        check("resume_stall",      stall,      1);
        tick();
        idle();
        settle();
        check("resume_state",  hz_state, 0);
        check("resume_halted", halted,   0);
        tick();

        // Resume outside HALT has no effect
        resume = 1;
        settle();
        check("stray_resume_flush", ifid_flush, 0);
        check("stray_resume_halted", halted, 0);
        tick();
        idle();
        settle();
        check("stray_resume_state", hz_state, 0);

        // Branch while draining for a fence
        id_valid = 1;
        tick(); tick();
        id_fence = 1;
        tick();
        settle();
        check("bf_state_drain", hz_state, 1);
        ex_branch_taken = 1;
        settle();
        check("bf_ifid_flush", ifid_flush, 1);
        check("bf_idex_flush", idex_flush, 1);
        check("bf_stall",      stall,      0);
        check("bf_pc_en",      pc_en,      1);
        tick();
        idle();
        settle();
        check("bf_state_run", hz_state, 0);
        tick();

        // Load-use colliding with a taken branch
        id_valid = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_rs_use = 2'b01;
        ex_branch_taken = 1;
        settle();
        check("col_ifid_flush", ifid_flush, 1);
        check("col_idex_flush", idex_flush, 1);
        check("col_stall",      stall,      0);
        check("col_pc_en",      pc_en,      1);
        tick();
        idle();
        tick(); tick(); tick();

        // Reset during HALT
        id_valid = 1; id_break = 1;
        tick();
        settle();
        check("rh_halted", halted, 1);
        rst_n = 0;
        settle();
        check("rh_rst_stall",  stall,  1);
        check("rh_rst_pc_en",  pc_en,  0);
        check("rh_rst_halted", halted, 0);
        tick();
        rst_n = 1;
        idle();
        settle();
        check("rh_state",  hz_state, 0);
        check("rh_halted_after", halted, 0);
        check("rh_occ",    dut.u_occ.r_occ, 0);
        check("rh_stall",  stall, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_stall_unit
`default_nettype wire
